// File: rtl/bitmap_index_encoder_pkg.sv
// Shared display-path constants and FSM encoding for the bitmap-to-index encoder.
package bitmap_index_encoder_pkg;

    localparam int DISP_WIDTH = 32;
    localparam int DISP_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bitmap_index_encoder_prio_enc_lsb.sv
// Combinational lowest-set-bit encoder; also flags empty and single-bit vectors.
module prio_enc_lsb
    import bitmap_index_encoder_pkg::*;
#(
    parameter int WIDTH = DISP_WIDTH,
    parameter int IDX_W = DISP_IDX_W
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             onehot
);

    logic found;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    assign any    = |vec;
    // A single set bit is exactly the isolated lowest bit.
    assign onehot = any && (vec == (WIDTH'(1) << idx));

endmodule

// File: rtl/bitmap_index_encoder.sv
// Captures a multi-hot bitmap and streams the indices of its set bits, lowest first.
module bitmap_index_encoder
    import bitmap_index_encoder_pkg::*;
#(
    parameter int WIDTH = DISP_WIDTH,
    parameter int IDX_W = DISP_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             done,
    output logic [IDX_W:0]   count
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [IDX_W:0]   load_pop;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_onehot;

    prio_enc_lsb #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_prio_enc (
        .vec    (pending_q),
        .idx    (enc_idx),
        .any    (enc_any),
        .onehot (enc_onehot)
    );

    always_comb begin
        load_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_pop = load_pop + {{IDX_W{1'b0}}, load_data[i]};
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        count_d    = count_q;
        load_ready = 1'b0;
        out_valid  = 1'b0;
        out_idx    = '0;
        out_last   = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                load_ready = ~rst;
                if (load_valid && load_ready) begin
                    pending_d = load_data;
                    count_d   = load_pop;
                    state_d   = (|load_data) ? ST_EMIT : ST_DONE;
                end
            end
            ST_EMIT: begin
                out_valid = enc_any;
                out_idx   = enc_idx;
                out_last  = enc_onehot;
                if (out_ready) begin
                    // Clearing the lowest set bit retires exactly the beat just accepted.
                    pending_d = pending_q & (pending_q - WIDTH'(1));
                    if (enc_onehot) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: pending is cleared too, so a reset drops any partial stream.
            state_q   <= ST_IDLE;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_bitmap_index_encoder.sv
// Randomized self-checking bench: a queue-of-indices reference model checked every cycle.
module tb_bitmap_index_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        done;
    logic [5:0]  count;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: remaining indices, pending done pulse, latched popcount.
    int m_q[$];
    bit m_done = 1'b0;
    int m_count = 0;

    bitmap_index_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_done  = 1'b0;
            m_count = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_q.size() != 0) begin
            if (out_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (load_valid) begin
            for (int i = 0; i < 32; i++) if (load_data[i]) m_q.push_back(i);
            m_count = $countones(load_data);
            if (m_q.size() == 0) m_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_out_valid", out_valid, m_q.size() != 0);
            check("cmp_out_idx", out_idx, (m_q.size() != 0) ? m_q[0] : 0);
            check("cmp_out_last", out_last, m_q.size() == 1);
            check("cmp_done", done, m_done);
            check("cmp_count", count, m_count);
            check("cmp_load_ready", load_ready, !rst && m_q.size() == 0 && !m_done);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bitmap(input logic [31:0] data);
        int guard = 0;
        while (!(m_q.size() == 0 && !m_done) && guard < 200) begin
            step();
            guard++;
        end
        load_valid = 1'b1;
        load_data  = data;
        step();
        load_valid = 1'b0;
        load_data  = $urandom;
    endtask

    function automatic logic [31:0] rand_bitmap();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h1 << $urandom_range(0, 31);
            3:       return $urandom & $urandom & $urandom;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'h0000_00FF;
        out_ready  = 1'b1;

        // Reset held with a load request pending.
        step();
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_load_ready", load_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_done", done, 0);
            check("rst_count", count, 0);
            if (i < 2) step();
        end
        load_valid = 1'b0;
        rst        = 1'b0;
        step();
        check("post_rst_load_ready", load_ready, 1);

        // Single bit.
        load_bitmap(32'h0000_0001);
        check("t2_valid", out_valid, 1);
        check("t2_idx", out_idx, 0);
        check("t2_last", out_last, 1);
        step();
        check("t2_done", done, 1);
        check("t2_count", count, 1);
        step();
        check("t2_ready", load_ready, 1);

        // Sparse bits at both ends.
        load_bitmap(32'h8000_0011);
        check("t3_idx0", out_idx, 0);
        check("t3_last0", out_last, 0);
        step();
        check("t3_idx4", out_idx, 4);
        check("t3_last4", out_last, 0);
        step();
        check("t3_idx31", out_idx, 31);
        check("t3_last31", out_last, 1);
        step();
        check("t3_done", done, 1);
        check("t3_count", count, 3);
        check("t3_model_count", m_count, 3);

        // Back-pressure holds the beat stable.
        out_ready = 1'b0;
        load_bitmap(32'h0000_0300);
        for (int i = 0; i < 4; i++) begin
            check("t4_stall_valid", out_valid, 1);
            check("t4_stall_idx", out_idx, 8);
            if (i < 3) step();
        end
        out_ready = 1'b1;
        #1;
        check("t4_idx8", out_idx, 8);
        step();
        check("t4_idx9", out_idx, 9);
        check("t4_last9", out_last, 1);
        step();
        check("t4_done", done, 1);

        // Empty bitmap.
        load_bitmap(32'h0);
        check("t5_valid", out_valid, 0);
        check("t5_done", done, 1);
        check("t5_count", count, 0);

        // All ones, then reset mid-stream.
        load_bitmap(32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
            check("t6_idx", out_idx, i);
            check("t6_last", out_last, i == 31);
            step();
        end
        check("t6_done", done, 1);
        check("t6_count", count, 32);
        load_bitmap(32'hFFFF_FFFF);
        for (int i = 0; i < 10; i++) step();
        check("t6_idx10", out_idx, 10);
        rst = 1'b1;
        step();
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_count", count, 0);
        rst = 1'b0;
        #1;
        check("t6_rst_ready", load_ready, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step();
            out_ready  = ($urandom_range(0, 9) < 7);
            load_valid = $urandom_range(0, 1);
            load_data  = rand_bitmap();
            rst        = ($urandom_range(0, 199) == 0);
        end
        rst        = 1'b0;
        load_valid = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
